fp_mul_arbiter: RTL

Round-robin arbiter and sequencer that shares one sequential FP32 multiplier core between two independent requesters. It latches the winning requester's operands, drives the core's start/done handshake, and returns the registered product with a per-port acknowledge. It sits between client logic and the core, in place of the single-client input/output wrappers.

---
 rtl/fp_mul_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter
// Shares one sequential FP32 multiplier core between two requesters using
// round-robin arbitration. The winner's operands are latched and held for the
// whole operation; the core's start/done handshake is sequenced; the product
// is returned in a shared registered result with a one-cycle per-port ack.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   req0/req1           level requests, held until the matching ack
//   a0,b0 / a1,b1       FP32 operands per port
//   ack0/ack1           one-cycle pulse, result valid for that port
//   result              registered product (holds until next capture)
//   busy                high whenever the sequencer is not idle
//   fp_start            one-cycle start pulse to the core
//   fp_a/fp_b           registered operands to the core
//   fp_done             core idle status
//   fp_result           core output, valid when fp_done returns high
//   timeout_err         (FPMUL_ARB_TIMEOUT_EN only) pulses with the ack on timeout
//
// Build option: define FPMUL_ARB_TIMEOUT_EN to add a watchdog of
// TIMEOUT_CYCLES cycles over the WAIT_LOW/WAIT_HIGH states.
module fp_mul_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] result,
  output logic        busy,
  output logic        fp_start,
  output logic [31:0] fp_a,
  output logic [31:0] fp_b,
  input  logic        fp_done,
  input  logic [31:0] fp_result
`ifdef FPMUL_ARB_TIMEOUT_EN
  ,
  output logic        timeout_err
`endif
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_LOW,
    WAIT_HIGH,
    RESP
  } state_t;

  state_t state, state_next;
  logic   gnt_id;    // port currently being served
  logic   last_gnt;  // port served most recently (round-robin pointer)
  logic   mask_vld;  // high in the IDLE cycle right after RESP
  logic   eff0, eff1, grant, win;
  logic   tmo_hit;

`ifdef FPMUL_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt;
  logic             timed_out;

  // Completion in WAIT_HIGH wins over a simultaneous timeout.
  assign tmo_hit = (cnt == CNT_LAST) &&
                   ((state == WAIT_LOW) || ((state == WAIT_HIGH) && !fp_done));
  assign timeout_err = (state == RESP) && timed_out;
`else
  assign tmo_hit = 1'b0;
`endif

  // The just-acked port is ignored for one IDLE cycle so a client that
  // registers ack can drop req a cycle late without a spurious regrant.
  always_comb begin
    eff0  = req0 && !(mask_vld && !gnt_id);
    eff1  = req1 && !(mask_vld && gnt_id);
    grant = fp_done && (eff0 || eff1);
    win   = (eff0 && eff1) ? !last_gnt : eff1;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (grant) state_next = ISSUE;
      ISSUE:     state_next = WAIT_LOW;
      WAIT_LOW: begin
        if (tmo_hit)       state_next = RESP;
        else if (!fp_done) state_next = WAIT_HIGH;
      end
      WAIT_HIGH: if (fp_done || tmo_hit) state_next = RESP;
      RESP:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    fp_start = (state == ISSUE);
    busy     = (state != IDLE);
    ack0     = (state == RESP) && !gnt_id;
    ack1     = (state == RESP) && gnt_id;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fp_a     <= '0;
      fp_b     <= '0;
      result   <= '0;
      gnt_id   <= 1'b0;
      last_gnt <= 1'b1;
      mask_vld <= 1'b0;
    end else begin
      state    <= state_next;
      mask_vld <= (state == RESP);
      if ((state == IDLE) && grant) begin
        gnt_id   <= win;
        last_gnt <= win;
        fp_a     <= win ? a1 : a0;
        fp_b     <= win ? b1 : b0;
      end
      if ((state == WAIT_HIGH) && fp_done) begin
        result <= fp_result;
      end else if (tmo_hit) begin
        result <= 32'h7FC0_0000;
      end
    end
  end

`ifdef FPMUL_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      timed_out <= 1'b0;
    end else begin
      if (state == ISSUE) begin
        cnt       <= '0;
        timed_out <= 1'b0;
      end else if ((state == WAIT_LOW) || (state == WAIT_HIGH)) begin
        cnt <= cnt + 1'b1;
        if (tmo_hit) timed_out <= 1'b1;
      end
    end
  end
`endif

endmodule
